pipelined_functional_unit: RTL
==============================

Name: pipelined_functional_unit

Overview:
Parametrised successor to the single-cycle combinational execute unit. It accepts one 139-bit issue-queue entry per cycle under a valid/ready handshake, decodes it internally, and executes integer ALU, LUI and load/store address operations. Results pass through a LATENCY-deep pipeline with per-stage valid bits, bubble collapsing, backpressure and flush. It sits between the issue queue and the CDB/ROB writeback and LSQ arbiter.

Parameters:
XLEN, 32, operand/result width (entry layout fixed for 32)
PREG_BITS, 6, physical register tag width
ROB_BITS, 6, ROB index width
LATENCY, 2, pipeline stages issue->output (legal 1..8)
FU_ID, 0, 2-bit unit id; entries whose FU_count field differs are rejected

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  issue entry valid
in_ready  out  1  unit can accept entry this cycle
in_entry  in  139  [138:136]funct3 [135:129]funct7 [128:122]opcode [121:116]rd [115:110]rs1 [109:78]rs1_val [77:72]rs2 [71:40]rs2_val [39:8]imm [7:2]rob_idx [1:0]fu_count
flush  in  1  kill all in-flight and same-cycle issued ops
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  XLEN  ALU result / effective address / LUI value
out_zero  out  1  out_result == 0
out_dest_reg  out  PREG_BITS  physical rd
out_rob_index  out  ROB_BITS  ROB entry
out_store_data  out  XLEN  rs2_val on stores, else 0
out_mem_write  out  1  store
out_mem_read  out  1  load
out_mem_size  out  1  1 = word (funct3 010), 0 = byte
out_reg_write  out  1  writes rd
busy  out  1  any stage valid

Behaviour:
- Clock is clk; reset is synchronous and active-high. On reset: all stage valids 0, out_valid 0, every out_* payload 0, busy 0. Reset mid-operation drops all in-flight ops; nothing emitted the cycle after.
- Accept: in_valid && in_ready && in_entry[1:0]==FU_ID && !flush. Entries with mismatched FU id are ignored (no state change).
- Decode in stage 1:
  - R-type 0110011: funct3 000 ADD, or SUB when funct7=0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7=0100000; 110 OR; 111 AND. B=rs2_val, reg_write=1.
  - I-type 0010011: same ops with B=imm; SUB never, SRAI when funct7=0100000. reg_write=1.
  - Load 0000011: result=rs1+imm, mem_read=1, reg_write=1.
  - Store 0100011: result=rs1+imm, mem_write=1, store_data=rs2_val, reg_write=0.
  - LUI 0110111: result=imm, reg_write=1.
  - Other opcodes: result 0, all control 0; still emitted so the ROB entry completes.
- Shifts use B[4:0]; arithmetic wraps mod 2^32; SLT is signed, SLTU unsigned.
- Pipeline: stage k holds a valid bit and full payload. Stage LATENCY drives out_*; out_valid = its valid.
- Stage k advances when stage k+1 is empty or advancing; last stage advances when out_ready. Bubbles collapse.
- in_ready = stage 1 empty or advancing.
- With out_ready held 1, an op accepted in cycle t appears with out_valid in cycle t+LATENCY. Throughput is 1 op/cycle.
- Payload is held stable while out_valid && !out_ready.
- Flush: all stage valids clear on the next edge and the same-cycle input is not accepted. in_ready may be 1 during flush. Flush wins over a simultaneous out handshake: the consumer must treat a flush cycle as no transfer. Flush and reset are equivalent for valid bits; payloads are not cleared on flush.
- When out_valid=0, out_* payload is 0 (gated at output).
- busy = OR of stage valids.

Test Plan:
- LATENCY=2, out_ready=1: ADD rs1=5, rs2=7, rd=12, rob=3, issued cycle 0 -> cycle 2 out_valid=1, result=12, dest=12, rob=3, reg_write=1, zero=0.
- SUB 7-7 -> result 0, zero=1. SRA 0x80000000 by 4 -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1. SLT -> 0.
- Store rs1=0x100, imm=8, rs2_val=0xDEADBEEF, funct3=010 -> result 0x108, store_data 0xDEADBEEF, mem_write=1, mem_size=1, reg_write=0. Byte load (funct3=000) -> mem_read=1, mem_size=0.
- Back-to-back issue of 4 ops, then out_ready=0 for 3 cycles: in_ready falls after the pipeline fills, outputs stay stable, no op is lost or duplicated, order is preserved on release.
- Flush with 2 ops in flight and in_valid=1 -> next cycle busy=0, out_valid=0; the flushed entries never appear.
- in_entry[1:0]=2 with FU_ID=0 -> ignored; reset asserted mid-stream -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/pipelined_functional_unit.sv
// Pipelined integer execute unit: decodes a 139-bit issue entry, computes ALU/LUI/address results
// and carries them through a LATENCY-deep elastic pipeline with backpressure and flush.
module pipelined_functional_unit #(
  parameter int         XLEN      = 32,
  parameter int         PREG_BITS = 6,
  parameter int         ROB_BITS  = 6,
  parameter int         LATENCY   = 2,
  parameter logic [1:0] FU_ID     = 2'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [138:0]         in_entry,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_result,
  output logic                 out_zero,
  output logic [PREG_BITS-1:0] out_dest_reg,
  output logic [ROB_BITS-1:0]  out_rob_index,
  output logic [XLEN-1:0]      out_store_data,
  output logic                 out_mem_write,
  output logic                 out_mem_read,
  output logic                 out_mem_size,
  output logic                 out_reg_write,
  output logic                 busy
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0]      result;
    logic [XLEN-1:0]      store_data;
    logic [PREG_BITS-1:0] dest;
    logic [ROB_BITS-1:0]  rob;
    logic                 mem_write;
    logic                 mem_read;
    logic                 mem_size;
    logic                 reg_write;
  } payload_t;

  // alt selects SUB for funct3 000 and arithmetic shift for funct3 101
  function automatic logic [XLEN-1:0] alu_op(input logic [2:0] f3, input logic alt,
                                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic [4:0]      sh;
    sh = b[4:0];
    r  = '0;
    case (f3)
      3'b000: begin
        if (alt) r = a - b;
        else     r = a + b;
      end
      3'b001: r = a << sh;
      3'b010: r[0] = ($signed(a) < $signed(b));
      3'b011: r[0] = (a < b);
      3'b100: r = a ^ b;
      3'b101: begin
        if (alt) r = $signed(a) >>> sh;
        else     r = a >> sh;
      end
      3'b110: r = a | b;
      3'b111: r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [6:0]      opcode;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm;
  logic            unused_fields;

  assign f3            = in_entry[138:136];
  assign f7            = in_entry[135:129];
  assign opcode        = in_entry[128:122];
  assign rs1_val       = in_entry[109:78];
  assign rs2_val       = in_entry[71:40];
  assign imm           = in_entry[39:8];
  assign unused_fields = ^{in_entry[115:110], in_entry[77:72]};

  payload_t dec;

  // Stage-1 decode of the incoming entry
  always_comb begin
    dec            = '0;
    dec.dest       = PREG_BITS'(in_entry[121:116]);
    dec.rob        = ROB_BITS'(in_entry[7:2]);
    case (opcode)
      OP_R: begin
        dec.result    = alu_op(f3, f7 == F7_ALT, rs1_val, rs2_val);
        dec.reg_write = 1'b1;
      end
      OP_I: begin
        dec.result    = alu_op(f3, (f3 == 3'b101) && (f7 == F7_ALT), rs1_val, imm);
        dec.reg_write = 1'b1;
      end
      OP_LOAD: begin
        dec.result    = rs1_val + imm;
        dec.mem_read  = 1'b1;
        dec.mem_size  = (f3 == 3'b010);
        dec.reg_write = 1'b1;
      end
      OP_STORE: begin
        dec.result     = rs1_val + imm;
        dec.mem_write  = 1'b1;
        dec.mem_size   = (f3 == 3'b010);
        dec.store_data = rs2_val;
      end
      OP_LUI: begin
        dec.result    = imm;
        dec.reg_write = 1'b1;
      end
      default: dec.result = '0;
    endcase
  end

  logic [LATENCY:1] vld;
  logic [LATENCY:1] take;
  payload_t         pay [1:LATENCY];
  logic             accept;

  // A stage can load when it is empty or its content moves on this cycle
  always_comb begin
    logic [LATENCY:1] t;
    t          = '0;
    t[LATENCY] = !vld[LATENCY] || out_ready;
    for (int k = LATENCY - 1; k >= 1; k--) begin
      t[k] = !vld[k] || t[k+1];
    end
    take = t;
  end

  assign in_ready = take[1];
  assign accept   = in_valid && in_ready && (in_entry[1:0] == FU_ID) && !flush;

  // Pipeline valid bits and payload shift; flush only kills valids
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int k = 1; k <= LATENCY; k++) begin
        pay[k] <= '0;
      end
    end else begin
      if (take[1]) begin
        vld[1] <= accept;
        if (accept) begin
          pay[1] <= dec;
        end
      end
      for (int k = 2; k <= LATENCY; k++) begin
        if (take[k]) begin
          vld[k] <= vld[k-1];
          pay[k] <= pay[k-1];
        end
      end
      if (flush) begin
        vld <= '0;
      end
    end
  end

  assign out_valid      = vld[LATENCY];
  assign out_result     = out_valid ? pay[LATENCY].result     : '0;
  assign out_store_data = out_valid ? pay[LATENCY].store_data : '0;
  assign out_dest_reg   = out_valid ? pay[LATENCY].dest       : '0;
  assign out_rob_index  = out_valid ? pay[LATENCY].rob        : '0;
  assign out_mem_write  = out_valid && pay[LATENCY].mem_write;
  assign out_mem_read   = out_valid && pay[LATENCY].mem_read;
  assign out_mem_size   = out_valid && pay[LATENCY].mem_size;
  assign out_reg_write  = out_valid && pay[LATENCY].reg_write;
  assign out_zero       = out_valid && (pay[LATENCY].result == '0);
  assign busy           = |vld;

endmodule
